// File: rtl/arith_unit_seq.sv
// Sequential arithmetic unit: single-cycle add/sub/shift-left, WIDTH-cycle shift-add multiply.
// Results are held in DONE until the consumer accepts them.
module arith_unit_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_SHL = 2'b11} op_t;

    state_t state, state_nxt;
    op_t    op_in, op_r;

    logic [WIDTH-1:0]   a_r;
    logic [2*WIDTH-1:0] p_r;
    logic [2*WIDTH-1:0] p_step;
    logic [WIDTH:0]     step_sum;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               mul_last;

    logic [WIDTH-1:0]   add_res;
    logic [WIDTH-1:0]   sub_res;
    logic [2*WIDTH-1:0] shl_wide;
    logic [WIDTH-1:0]   imm_out;
    logic               imm_ovf;

    assign op_in     = op_t'(sel);
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign mul_last  = (cnt == CW'(WIDTH - 1));

    // p_r holds {partial product, remaining multiplier bits}; one shift-add per cycle
    always_comb begin
        step_sum = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, a_r} : '0);
        p_step   = {step_sum, p_r[WIDTH-1:1]};
    end

    always_comb begin
        add_res  = ina + inb;
        sub_res  = ina - inb;
        shl_wide = {{WIDTH{1'b0}}, ina} << inb;
        imm_out  = '0;
        imm_ovf  = 1'b0;
        case (op_in)
            OP_ADD: begin
                imm_out = add_res;
                imm_ovf = (ina[WIDTH-1] == inb[WIDTH-1]) && (add_res[WIDTH-1] != ina[WIDTH-1]);
            end
            OP_SUB: begin
                imm_out = sub_res;
                imm_ovf = (ina[WIDTH-1] != inb[WIDTH-1]) && (sub_res[WIDTH-1] != ina[WIDTH-1]);
            end
            OP_SHL: begin
                if (inb >= WIDTH'(WIDTH)) begin
                    imm_out = '0;
                    imm_ovf = |ina;
                end else begin
                    imm_out = shl_wide[WIDTH-1:0];
                    imm_ovf = |shl_wide[2*WIDTH-1:WIDTH];
                end
            end
            default: begin
                imm_out = '0;
                imm_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (op_in == OP_MUL) ? BUSY : DONE;
            BUSY: if (mul_last || op_r != OP_MUL) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            p_r      <= '0;
            op_r     <= OP_ADD;
            cnt      <= '0;
            out      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_r  <= ina;
            p_r  <= {{WIDTH{1'b0}}, inb};
            op_r <= op_in;
            cnt  <= '0;
            if (op_in != OP_MUL) begin
                out      <= imm_out;
                overflow <= imm_ovf;
            end
        end else if (state == BUSY) begin
            p_r <= p_step;
            // last iteration writes the result directly so DONE follows with no extra cycle
            if (mul_last) begin
                out      <= p_step[WIDTH-1:0];
                overflow <= |p_step[2*WIDTH-1:WIDTH];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_arith_unit_seq.sv
// Scoreboard bench for arith_unit_seq (WIDTH=16): directed vectors, backpressure,
// reset abort and random operations checked against an independent model.
module tb_arith_unit_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] ina = '0;
    logic [W-1:0] inb = '0;
    logic [1:0]   sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    arith_unit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ina(ina), .inb(inb), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
        logic [W-1:0]   r;
        logic           o;
        logic [2*W-1:0] w;
        int             sv;
        r = '0;
        o = 1'b0;
        case (s)
            2'b00: begin
                sv = int'($signed(a)) + int'($signed(b));
                r  = W'(sv);
                o  = (sv > 32767) || (sv < -32768);
            end
            2'b01: begin
                sv = int'($signed(a)) - int'($signed(b));
                r  = W'(sv);
                o  = (sv > 32767) || (sv < -32768);
            end
            2'b10: begin
                w = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = w[W-1:0];
                o = (w[2*W-1:W] != '0);
            end
            default: begin
                if (int'(b) >= W) begin
                    r = '0;
                    o = (a != '0);
                end else begin
                    w = {{W{1'b0}}, a} << b;
                    r = w[W-1:0];
                    o = (w[2*W-1:W] != '0);
                end
            end
        endcase
        return {o, r};
    endfunction

    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("out", 64'(out), 64'(e[W-1:0]));
                check("ovf", 64'(overflow), 64'(e[W]));
            end
        end
    end

    // Issue one operation, verify latency, optionally hold the result for 'hold' cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                          input int hold, input logic [W:0] e);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'(1));
        ina = a; inb = b; sel = s; in_valid = 1'b1;
        out_ready = (hold == 0);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ina = W'($urandom); inb = W'($urandom); sel = 2'($urandom);
        check("busy_ready", 64'(in_ready), 64'(0));
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'((s == 2'b10) ? W + 1 : 1));
        if (hold > 0) begin
            in_valid = 1'b1;
            repeat (hold) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_out", 64'(out), 64'(e[W-1:0]));
                check("hold_ovf", 64'(overflow), 64'(e[W]));
                check("hold_ready", 64'(in_ready), 64'(0));
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("handoff_valid", 64'(out_valid), 64'(0));
        check("handoff_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rs;

        #12;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out", 64'(out), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 64'(in_ready), 64'(1));

        run_op(16'h7FFF, 16'h0001, 2'b00, 0, {1'b1, 16'h8000});
        run_op(16'h1234, 16'h00FF, 2'b00, 0, {1'b0, 16'h1333});
        run_op(16'h8000, 16'h0001, 2'b01, 0, {1'b1, 16'h7FFF});
        run_op(16'h0005, 16'h0007, 2'b01, 0, {1'b0, 16'hFFFE});
        run_op(16'h00FF, 16'h00FF, 2'b10, 0, {1'b0, 16'hFE01});
        run_op(16'h0100, 16'h0100, 2'b10, 0, {1'b1, 16'h0000});
        run_op(16'h00F0, 16'd8,    2'b11, 5, {1'b0, 16'hF000});
        run_op(16'h00F0, 16'd9,    2'b11, 0, {1'b1, 16'hE000});
        run_op(16'h00F0, 16'd200,  2'b11, 0, {1'b1, 16'h0000});
        run_op(16'hABCD, 16'd0,    2'b11, 0, {1'b0, 16'hABCD});
        run_op(16'hFFFF, 16'hFFFF, 2'b10, 2, {1'b1, 16'h0001});

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rs = 2'($urandom);
            rb = (rs == 2'b11) ? W'($urandom_range(0, 20)) : W'($urandom);
            run_op(ra, rb, rs, $urandom_range(0, 2), model(ra, rb, rs));
        end

        run_op(16'h1234, 16'h00FF, 2'b00, 0, {1'b0, 16'h1333});
        ina = 16'd3; inb = 16'd5; sel = 2'b10; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_busy_ready", 64'(in_ready), 64'(0));
        repeat (6) @(posedge clk);
        #1;
        check("abort_pre_valid", 64'(out_valid), 64'(0));
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_out", 64'(out), 64'(0));
        check("abort_ovf", 64'(overflow), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_rel_ready", 64'(in_ready), 64'(1));
        check("abort_rel_valid", 64'(out_valid), 64'(0));
        run_op(16'h4000, 16'h4000, 2'b00, 0, {1'b1, 16'h8000});

        repeat (3) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arith_unit_seq.md
ARITH_UNIT_SEQ -- requirements
Module: arith_unit_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width (legal 4..64).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  operation request valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 The block SHALL have port ina  input  WIDTH  operand A.
REQ-007 The block SHALL have port inb  input  WIDTH  operand B.
REQ-008 The block SHALL have port sel  input  2  opcode: 00 add, 01 sub, 10 multiply, 11 shift-left.
REQ-009 The block SHALL have port out_valid  output  1  result valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port out  output  WIDTH  result.
REQ-012 The block SHALL have port overflow  output  1  overflow flag qualified by out_valid.

Function
REQ-013 The block SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-014 The block SHALL accept an operation when in_valid && in_ready, registering ina, inb, sel in that cycle; inputs are ignored at all other times.
REQ-015 For sel 00/01/11 the block SHALL go IDLE -> DONE, with out_valid asserted the cycle after acceptance (latency 1).
REQ-016 For sel 10 the block SHALL go IDLE -> BUSY, run WIDTH shift-add iterations (one per cycle), then go to DONE, with out_valid asserted WIDTH+1 cycles after acceptance.
REQ-017 In DONE, the block SHALL hold out, overflow and out_valid stable until out_ready = 1, then return to IDLE the next cycle; no new operation is accepted in the same cycle as result hand-off.
REQ-018 Add SHALL produce out = (ina+inb) mod 2^WIDTH and overflow = signed two's-complement overflow (operands same sign, result sign differs).
REQ-019 Sub SHALL produce out = (ina-inb) mod 2^WIDTH and overflow = signed overflow (operand signs differ, result sign differs from ina).
REQ-020 Multiply SHALL be unsigned: out = low WIDTH bits of the 2*WIDTH product; overflow = 1 iff the high WIDTH bits are nonzero.
REQ-021 Shift-left SHALL produce out = ina << inb (unsigned amount); overflow = 1 iff any 1 bit is shifted out; if inb >= WIDTH then out = 0 and overflow = (ina != 0); inb = 0 gives out = ina, overflow = 0.
REQ-022 The iteration counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.
REQ-023 out and overflow SHALL be don't-care-free: when out_valid = 0 they hold their last registered value.
REQ-024 out_ready asserted while not in DONE SHALL have no effect.

Reset
REQ-025 While rst_n = 0, the block SHALL force state IDLE, in_ready = 1 once released (0 during reset), out_valid = 0, out = 0, overflow = 0, counter and operand registers = 0, asynchronously.
REQ-026 Reset asserted during BUSY or DONE SHALL abort the operation with no result delivered; the first cycle after release SHALL be IDLE.

Verification (WIDTH=16)
REQ-027 Add: ina=0x7FFF, inb=0x0001, sel=00 -> next cycle out_valid=1, out=0x8000, overflow=1; ina=0x1234, inb=0x00FF -> out=0x1333, overflow=0.
REQ-028 Sub: ina=0x8000, inb=0x0001, sel=01 -> out=0x7FFF, overflow=1; ina=0x0005, inb=0x0007 -> out=0xFFFE, overflow=0.
REQ-029 Multiply: ina=0x00FF, inb=0x00FF, sel=10 -> in_ready=0 for 17 cycles, out_valid at cycle 17, out=0xFE01, overflow=0; ina=0x0100, inb=0x0100 -> out=0x0000, overflow=1.
REQ-030 Shift: ina=0x00F0, inb=8, sel=11 -> out=0xF000, overflow=0; inb=9 -> out=0xE000, overflow=1; inb=200 -> out=0, overflow=1.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out/overflow stable, in_ready=0, new in_valid ignored; raise out_ready -> IDLE next cycle.
REQ-032 Reset mid-multiply: assert rst_n=0 at BUSY cycle 7 -> out_valid=0, out=0 immediately; after release in_ready=1 and a fresh add completes correctly.
